// File: rtl/register_file.sv
// Two-read, one-write register file with registered read ports and write-first bypass.
// Synchronous active-low reset clears all storage and both read outputs.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] mem_d [Depth];
   logic [DATA_WIDTH-1:0] out1_q, out1_d;
   logic [DATA_WIDTH-1:0] out2_q, out2_d;

   always_comb begin
      mem_d = mem_q;
      if (write_enable) begin
         mem_d[in_addr] = in_data;
      end
      out1_d = out1_q;
      out2_d = out2_q;
      // Reading the post-write image gives write-first bypass on both ports.
      if (read_enable) begin
         out1_d = mem_d[addr1];
         out2_d = mem_d[addr2];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q  <= '{default: '0};
         out1_q <= '0;
         out2_q <= '0;
      end else begin
         mem_q  <= mem_d;
         out1_q <= out1_d;
         out2_q <= out2_d;
      end
   end

   assign out1 = out1_q;
   assign out2 = out2_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios, then randomized traffic
// compared against a simple array model of the register file.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned Depth = 2 ** AW;

   logic          clk;
   logic          reset;
   logic          read_enable;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [DW-1:0] out1;
   logic [DW-1:0] out2;
   logic          write_enable;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;

   logic [DW-1:0] model [Depth];
   logic [DW-1:0] exp1, exp2;
   int            checks = 0;
   int            passed = 0;

   register_file #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .read_enable  (read_enable),
      .addr1        (addr1),
      .addr2        (addr2),
      .out1         (out1),
      .out2         (out2),
      .write_enable (write_enable),
      .in_addr      (in_addr),
      .in_data      (in_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv,
                  expv);
   endtask

   // Apply one cycle of inputs, advance the model at the edge, then settle past the edge.
   task automatic cycle(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
      reset        = rst;
      write_enable = we;
      in_addr      = wa;
      in_data      = wd;
      read_enable  = re;
      addr1        = a1;
      addr2        = a2;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < Depth; i++) model[i] = '0;
         exp1 = '0;
         exp2 = '0;
      end else begin
         if (we) model[wa] = wd;
         if (re) begin
            exp1 = model[a1];
            exp2 = model[a2];
         end
      end
      #1;
   endtask

   initial begin
      logic          r_rst, r_we, r_re;
      logic [AW-1:0] r_wa, r_a1, r_a2;
      logic [DW-1:0] r_wd;

      for (int i = 0; i < Depth; i++) model[i] = 'x;
      exp1 = 'x;
      exp2 = 'x;
      reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
      addr1 = '0; addr2 = '0; in_addr = '0; in_data = '0;
      #2;

      // Reset held for two edges, with a write attempted that must be discarded.
      cycle(1'b0, 1'b1, 5'd3, 32'd111, 1'b1, 5'd0, 5'd2);
      cycle(1'b0, 1'b1, 5'd3, 32'd111, 1'b1, 5'd0, 5'd2);
      check("reset_out1", out1, 32'd0);
      check("reset_out2", out2, 32'd0);

      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd2);
      check("post_reset_rd_out1", out1, 32'd0);
      check("post_reset_rd_out2", out2, 32'd0);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);
      check("reset_discarded_wr", out1, 32'd0);

      cycle(1'b1, 1'b1, 5'd2, 32'd2222, 1'b1, 5'd0, 5'd2);
      check("wr2_bypass_out2", out2, 32'd2222);
      check("wr2_out1_zero", out1, 32'd0);

      cycle(1'b1, 1'b0, 5'd0, 32'd1234, 1'b1, 5'd0, 5'd2);
      cycle(1'b1, 1'b0, 5'd0, 32'd1234, 1'b1, 5'd0, 5'd2);
      check("we_low_no_write", out1, 32'd0);
      cycle(1'b1, 1'b1, 5'd0, 32'd1234, 1'b1, 5'd0, 5'd2);
      check("reg0_writable", out1, 32'd1234);

      cycle(1'b1, 1'b1, 5'd2, 32'd5678, 1'b1, 5'd0, 5'd2);
      check("wr5678", out2, 32'd5678);
      cycle(1'b1, 1'b1, 5'd2, 32'd9999, 1'b0, 5'd0, 5'd2);
      check("re_low_hold_out2", out2, 32'd5678);
      check("re_low_hold_out1", out1, 32'd1234);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd2);
      check("write_during_hold", out2, 32'd9999);

      cycle(1'b1, 1'b1, 5'd7, 32'd42, 1'b1, 5'd7, 5'd7);
      check("bypass_both_out1", out1, 32'd42);
      check("bypass_both_out2", out2, 32'd42);

      cycle(1'b0, 1'b1, 5'd2, 32'd77, 1'b1, 5'd2, 5'd2);
      check("reset_prio_out1", out1, 32'd0);
      check("reset_prio_out2", out2, 32'd0);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd7);
      check("cleared_addr2", out1, 32'd0);
      check("cleared_addr7", out2, 32'd0);

      // Randomized traffic against the model; bias toward address collisions.
      for (int n = 0; n < 400; n++) begin
         r_rst = ($urandom_range(0, 49) != 0);
         r_we  = ($urandom_range(0, 2) != 0);
         r_re  = ($urandom_range(0, 3) != 0);
         r_a1  = AW'($urandom);
         r_a2  = ($urandom_range(0, 4) == 0) ? r_a1 : AW'($urandom);
         r_wa  = ($urandom_range(0, 3) == 0) ? r_a2 : AW'($urandom);
         r_wd  = $urandom;
         cycle(r_rst, r_we, r_wa, r_wd, r_re, r_a1, r_a2);
         check("rand_out1", out1, exp1);
         check("rand_out2", out2, exp2);
      end

      // Final sweep: every register still holds its last written value.
      for (int a = 0; a < Depth; a++) begin
         cycle(1'b1, 1'b0, '0, '0, 1'b1, AW'(a), AW'(Depth - 1 - a));
         check("sweep_out1", out1, model[a]);
         check("sweep_out2", out2, model[Depth-1-a]);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
